// File: rtl/fp_add_rs_ctrl_pkg.sv
// Shared encodings for the FP add/sub reservation-station controller.
package fp_add_rs_ctrl_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultTagW  = 3;
  localparam int unsigned TagNone      = 0;

  typedef enum logic [1:0] {
    OpIdle = 2'd0,
    OpAdd  = 2'd1,
    OpSub  = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StBcast
  } unit_state_e;

endpackage

// File: rtl/fp_add_rs_ctrl_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping around.
module fp_add_rs_ctrl_rr_pick #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      pos = {1'b0, ptr_i} + (IdxW+1)'(off);
      if (pos >= (IdxW+1)'(NumReq)) begin
        pos = pos - (IdxW+1)'(NumReq);
      end
      if (!any_o && req_i[pos[IdxW-1:0]]) begin
        any_o                  = 1'b1;
        gnt_o[pos[IdxW-1:0]]   = 1'b1;
        idx_o                  = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_add_rs_ctrl.sv
// Reservation stations for the shared FP add/sub unit: issue, CDB snoop, one-at-a-time
// dispatch to the adder and result broadcast request.
module fp_add_rs_ctrl
  import fp_add_rs_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned TAG_W       = DefaultTagW,
  parameter int unsigned NUM_RS      = 3,
  parameter int unsigned RS_BASE_TAG = 1,
  parameter int unsigned ADD_LAT     = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              issue_valid,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              cdb_req,
  output logic [TAG_W-1:0]  cdb_req_tag,
  output logic [DATA_W-1:0] cdb_req_data,
  input  logic              cdb_grant,
  output logic [NUM_RS-1:0] rs_busy
);

  localparam int unsigned IdxW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int unsigned CntW = (ADD_LAT > 1) ? $clog2(ADD_LAT + 1) : 1;

  logic [NUM_RS-1:0] busy_q, busy_d, exec_q, ready;
  logic [1:0]        op_q [NUM_RS];
  logic [DATA_W-1:0] vj_q [NUM_RS];
  logic [DATA_W-1:0] vk_q [NUM_RS];
  logic [TAG_W-1:0]  qj_q [NUM_RS];
  logic [TAG_W-1:0]  qk_q [NUM_RS];

  unit_state_e       state_q;
  logic [IdxW-1:0]   rr_q, cur_q, free_idx, pick_idx;
  logic [CntW-1:0]   cnt_q;
  logic [NUM_RS-1:0] pick_gnt;
  logic              pick_any;
  logic              cdb_hit, issue_fire, dispatch, bcast_done, ready_d;
  logic [TAG_W-1:0]  tag_d;

  function automatic logic [TAG_W-1:0] tag_of(input logic [IdxW-1:0] idx);
    return TAG_W'(RS_BASE_TAG) + TAG_W'(idx);
  endfunction

  always_comb begin
    cdb_hit    = cdb_valid && (cdb_tag != TAG_W'(TagNone));
    issue_fire = issue_valid && issue_ready;
    dispatch   = (state_q == StIdle) && pick_any;
    bcast_done = (state_q == StBcast) && cdb_grant;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      ready[i] = busy_q[i] && !exec_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = int'(NUM_RS) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IdxW'(i);
    end
  end

  // issue_ready/issue_tag are registered from the post-edge occupancy, so a slot freed by a
  // grant is offered in the very next cycle.
  always_comb begin
    busy_d = busy_q;
    if (issue_fire) busy_d[free_idx] = 1'b1;
    if (bcast_done) busy_d[cur_q] = 1'b0;
    ready_d = 1'b0;
    tag_d   = '0;
    for (int i = int'(NUM_RS) - 1; i >= 0; i--) begin
      if (!busy_d[i]) begin
        ready_d = 1'b1;
        tag_d   = tag_of(IdxW'(i));
      end
    end
  end

  fp_add_rs_ctrl_rr_pick #(
    .NumReq (NUM_RS),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i (ready),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy_q <= '0;
      exec_q <= '0;
      for (int i = 0; i < int'(NUM_RS); i++) begin
        op_q[i] <= OpIdle;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      if (dispatch) exec_q <= exec_q | pick_gnt;
      if (bcast_done) exec_q[cur_q] <= 1'b0;
      // Executing entries already hold both operands and must not be disturbed.
      for (int i = 0; i < int'(NUM_RS); i++) begin
        if (cdb_hit && busy_q[i] && !exec_q[i]) begin
          if (qj_q[i] == cdb_tag) begin
            qj_q[i] <= '0;
            vj_q[i] <= cdb_data;
          end
          if (qk_q[i] == cdb_tag) begin
            qk_q[i] <= '0;
            vk_q[i] <= cdb_data;
          end
        end
      end
      if (issue_fire) begin
        op_q[free_idx] <= issue_op;
        vj_q[free_idx] <= issue_vj;
        vk_q[free_idx] <= issue_vk;
        qj_q[free_idx] <= issue_qj;
        qk_q[free_idx] <= issue_qk;
        if (cdb_hit && (issue_qj == cdb_tag)) begin
          qj_q[free_idx] <= '0;
          vj_q[free_idx] <= cdb_data;
        end
        if (cdb_hit && (issue_qk == cdb_tag)) begin
          qk_q[free_idx] <= '0;
          vk_q[free_idx] <= cdb_data;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      cur_q        <= '0;
      cnt_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= OpIdle;
      cdb_req      <= 1'b0;
      cdb_req_tag  <= '0;
      cdb_req_data <= '0;
      issue_ready  <= 1'b0;
      issue_tag    <= '0;
    end else begin
      issue_ready <= ready_d;
      issue_tag   <= tag_d;
      unique case (state_q)
        StIdle: begin
          if (dispatch) begin
            alu_a   <= vj_q[pick_idx];
            alu_b   <= vk_q[pick_idx];
            alu_op  <= op_q[pick_idx];
            cnt_q   <= CntW'(ADD_LAT);
            rr_q    <= (pick_idx == IdxW'(NUM_RS - 1)) ? '0 : pick_idx + IdxW'(1);
            cur_q   <= pick_idx;
            state_q <= StExec;
          end
        end
        StExec: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            cdb_req_data <= alu_result;
            cdb_req_tag  <= tag_of(cur_q);
            cdb_req      <= 1'b1;
            alu_op       <= OpIdle;
            state_q      <= StBcast;
          end
        end
        StBcast: begin
          if (cdb_grant) begin
            cdb_req <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rs_busy = busy_q;

endmodule

// File: tb/tb_fp_add_rs_ctrl.sv
// Bench for fp_add_rs_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_fp_add_rs_ctrl;

  localparam int DW   = 16;
  localparam int TW   = 3;
  localparam int N    = 3;
  localparam int BASE = 1;
  localparam int LAT  = 1;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          issue_valid;
  logic [1:0]    issue_op;
  logic [DW-1:0] issue_vj, issue_vk;
  logic [TW-1:0] issue_qj, issue_qk;
  logic          issue_ready;
  logic [TW-1:0] issue_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [1:0]    alu_op;
  logic          cdb_req;
  logic [TW-1:0] cdb_req_tag;
  logic [DW-1:0] cdb_req_data;
  logic          cdb_grant;
  logic [N-1:0]  rs_busy;

  always #5 Clock = ~Clock;

  // Single-cycle adder environment.
  always_comb alu_result = (alu_op == 2'd2) ? alu_a - alu_b : alu_a + alu_b;

  fp_add_rs_ctrl #(
    .DATA_W      (DW),
    .TAG_W       (TW),
    .NUM_RS      (N),
    .RS_BASE_TAG (BASE),
    .ADD_LAT     (LAT)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .issue_valid  (issue_valid),
    .issue_op     (issue_op),
    .issue_vj     (issue_vj),
    .issue_vk     (issue_vk),
    .issue_qj     (issue_qj),
    .issue_qk     (issue_qk),
    .issue_ready  (issue_ready),
    .issue_tag    (issue_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .cdb_req      (cdb_req),
    .cdb_req_tag  (cdb_req_tag),
    .cdb_req_data (cdb_req_data),
    .cdb_grant    (cdb_grant),
    .rs_busy      (rs_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: entry table plus the unit's phase (0 idle, 1 executing, 2 broadcasting).
  bit            m_busy [N];
  bit            m_exec [N];
  int            m_op   [N];
  logic [DW-1:0] m_vj   [N];
  logic [DW-1:0] m_vk   [N];
  int            m_qj   [N];
  int            m_qk   [N];
  int            m_phase, m_cnt, m_rr, m_cur;
  logic [DW-1:0] exp_res, e_alu_a, e_alu_b, e_req_data;
  int            e_alu_op, e_req_tag, e_tag;
  bit            e_ready, e_req;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int  slot, pick;
    bit  accept;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0; m_exec[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
      end
      m_phase = 0; m_cnt = 0; m_rr = 0; m_cur = 0;
      e_alu_a = '0; e_alu_b = '0; e_alu_op = 0;
      e_req = 0; e_req_tag = 0; e_req_data = '0; e_ready = 0; e_tag = 0;
      return;
    end
    accept = issue_valid && e_ready;
    slot = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) slot = i;
    pick = -1;
    if (m_phase == 0) begin
      for (int o = 0; o < N; o++) begin
        int j;
        j = (m_rr + o) % N;
        if (pick < 0 && m_busy[j] && !m_exec[j] && m_qj[j] == 0 && m_qk[j] == 0) pick = j;
      end
    end
    if (cdb_valid && cdb_tag != 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && !m_exec[i]) begin
          if (m_qj[i] == int'(cdb_tag)) begin m_qj[i] = 0; m_vj[i] = cdb_data; end
          if (m_qk[i] == int'(cdb_tag)) begin m_qk[i] = 0; m_vk[i] = cdb_data; end
        end
      end
    end
    if (accept) begin
      m_busy[slot] = 1; m_exec[slot] = 0; m_op[slot] = int'(issue_op);
      m_vj[slot] = issue_vj; m_qj[slot] = int'(issue_qj);
      m_vk[slot] = issue_vk; m_qk[slot] = int'(issue_qk);
      if (issue_qj != 0 && cdb_valid && issue_qj == cdb_tag) begin
        m_qj[slot] = 0; m_vj[slot] = cdb_data;
      end
      if (issue_qk != 0 && cdb_valid && issue_qk == cdb_tag) begin
        m_qk[slot] = 0; m_vk[slot] = cdb_data;
      end
    end
    if (m_phase == 0) begin
      if (pick >= 0) begin
        m_exec[pick] = 1;
        e_alu_a = m_vj[pick]; e_alu_b = m_vk[pick]; e_alu_op = m_op[pick];
        exp_res = (m_op[pick] == 2) ? m_vj[pick] - m_vk[pick] : m_vj[pick] + m_vk[pick];
        m_cnt = LAT; m_rr = (pick + 1) % N; m_cur = pick; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_cnt == 1) begin
        e_req = 1; e_req_tag = BASE + m_cur; e_req_data = exp_res; e_alu_op = 0; m_phase = 2;
      end
      m_cnt--;
    end else if (cdb_grant) begin
      e_req = 0; m_busy[m_cur] = 0; m_exec[m_cur] = 0; m_phase = 0;
    end
    e_ready = 0; e_tag = 0;
    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) begin e_ready = 1; e_tag = BASE + i; end
  endtask

  function automatic int busy_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic compare_all();
    chk("cdb_req", int'(cdb_req), int'(e_req));
    chk("rs_busy", int'(rs_busy), busy_vec());
    chk("alu_op", int'(alu_op), e_alu_op);
    chk("issue_ready", int'(issue_ready), int'(e_ready));
    if (e_ready) chk("issue_tag", int'(issue_tag), e_tag);
    if (e_alu_op != 0) begin
      chk("alu_a", int'(alu_a), int'(e_alu_a));
      chk("alu_b", int'(alu_b), int'(e_alu_b));
    end
    if (e_req) begin
      chk("cdb_req_tag", int'(cdb_req_tag), e_req_tag);
      chk("cdb_req_data", int'(cdb_req_data), int'(e_req_data));
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare_all();
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_op = 2'd1; issue_vj = '0; issue_vk = '0;
    issue_qj = '0; issue_qk = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; cdb_grant = 0;
  endtask

  task automatic set_issue(input int op, input int vj, input int qj, input int vk, input int qk);
    issue_valid = 1; issue_op = 2'(op);
    issue_vj = DW'(vj); issue_qj = TW'(qj);
    issue_vk = DW'(vk); issue_qk = TW'(qk);
  endtask

  task automatic set_cdb(input int tag, input int data);
    cdb_valid = 1; cdb_tag = TW'(tag); cdb_data = DW'(data);
  endtask

  // The arbiter grants and the result goes out on the CDB in the same cycle.
  task automatic grant_now();
    cdb_grant = 1;
    set_cdb(e_req_tag, int'(e_req_data));
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1; tick();
    Reset = 0; tick();
  endtask

  function automatic int rand_q();
    int r, cnt;
    int cand [N];
    r = int'($urandom_range(3));
    if (r < 2) return 0;
    if (r == 2) return 4 + int'($urandom_range(3));
    cnt = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) begin cand[cnt] = BASE + i; cnt++; end
    if (cnt == 0) return 0;
    return cand[$urandom_range(cnt - 1)];
  endfunction

  initial begin
    idle_inputs();
    Reset = 1;
    tick(); tick();
    chk("rst_cdb_req", int'(cdb_req), 0);
    chk("rst_ready", int'(issue_ready), 0);
    chk("rst_busy", int'(rs_busy), 0);
    Reset = 0;
    tick();
    chk("post_rst_ready", int'(issue_ready), 1);
    chk("post_rst_tag", int'(issue_tag), 1);

    // Plain add, operands valid at issue.
    set_issue(1, 3, 0, 4, 0); tick(); idle_inputs();
    chk("t1_busy", int'(rs_busy), 1);
    chk("t1_next_tag", int'(issue_tag), 2);
    tick();
    chk("t1_op", int'(alu_op), 1);
    chk("t1_a", int'(alu_a), 3);
    chk("t1_b", int'(alu_b), 4);
    tick();
    chk("t1_req", int'(cdb_req), 1);
    chk("t1_data", int'(cdb_req_data), 7);
    chk("t1_tag", int'(cdb_req_tag), 1);
    grant_now(); tick(); idle_inputs();
    chk("t1_free", int'(rs_busy), 0);

    // Sub waiting on tag 5, captured by a later broadcast.
    do_reset();
    set_issue(2, 0, 5, 2, 0); tick(); idle_inputs();
    set_cdb(5, 10); tick(); idle_inputs();
    chk("t2_wait", int'(alu_op), 0);
    tick();
    chk("t2_op", int'(alu_op), 2);
    chk("t2_a", int'(alu_a), 10);
    tick();
    chk("t2_data", int'(cdb_req_data), 8);
    grant_now(); tick(); idle_inputs();

    // Same-cycle bypass of the broadcast into the issuing entry.
    do_reset();
    set_issue(1, 0, 5, 1, 0); set_cdb(5, 9); tick(); idle_inputs();
    tick();
    chk("t3_op", int'(alu_op), 1);
    chk("t3_a", int'(alu_a), 9);
    tick();
    chk("t3_data", int'(cdb_req_data), 10);
    grant_now(); tick(); idle_inputs();

    // Fill, ignored issue, delayed grant, round-robin, then reset while broadcasting.
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_issue(1, 0, 6, i + 1, 0); tick();
    end
    chk("t4_full", int'(issue_ready), 0);
    chk("t4_busy", int'(rs_busy), 7);
    set_issue(1, 0, 0, 99, 0); tick(); idle_inputs();
    chk("t4_ignored", int'(rs_busy), 7);
    set_cdb(6, 100); tick(); idle_inputs();
    tick();
    chk("t4_a", int'(alu_a), 100);
    chk("t4_b", int'(alu_b), 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_hold_req", int'(cdb_req), 1);
      chk("t5_hold_data", int'(cdb_req_data), 101);
      chk("t5_hold_tag", int'(cdb_req_tag), 1);
    end
    grant_now(); tick(); idle_inputs();
    chk("t4_ready_again", int'(issue_ready), 1);
    chk("t4_tag_reuse", int'(issue_tag), 1);
    tick();
    chk("t5_rr_b", int'(alu_b), 2);
    tick();
    chk("t5_rr_tag", int'(cdb_req_tag), 2);
    chk("t5_rr_data", int'(cdb_req_data), 102);
    Reset = 1; tick();
    chk("t6_req", int'(cdb_req), 0);
    chk("t6_op", int'(alu_op), 0);
    chk("t6_busy", int'(rs_busy), 0);
    Reset = 0; tick();
    chk("t6_tag", int'(issue_tag), 1);
    chk("t6_ready", int'(issue_ready), 1);

    // Random traffic with occasional mid-run reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      idle_inputs();
      Reset = ($urandom_range(599) == 0);
      if (e_req && $urandom_range(2) == 0) begin
        grant_now();
      end else if ($urandom_range(3) == 0) begin
        r = int'($urandom_range(4));
        set_cdb((r == 0) ? 0 : r + 3, int'($urandom_range(65535)));
      end
      if ($urandom_range(1) == 0) begin
        set_issue(1 + int'($urandom_range(1)), int'($urandom_range(65535)), rand_q(),
                  int'($urandom_range(65535)), rand_q());
      end
      tick();
    end
    Reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
